// File: rtl/vga_row_writer_fsm_if.sv
// Handshake/address bundle between the automaton core, the row writer and the frame memory.
interface vga_row_writer_fsm_if #(
  parameter int COL_W = 5,
  parameter int ROW_W = 8
);
  logic             load;
  logic             clear;
  logic             key_n;
  logic             mem_ready;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             load_mem;
  logic             wr_clear;
  logic             ack;
  logic             frame_done;
  logic             busy;

  modport master (
    output load, clear, key_n, mem_ready,
    input  col, row, load_mem, wr_clear, ack, frame_done, busy
  );

  modport slave (
    input  load, clear, key_n, mem_ready,
    output col, row, load_mem, wr_clear, ack, frame_done, busy
  );
endinterface

// File: rtl/vga_row_writer_fsm.sv
// Row-write sequencer: streams one NUM_COLS row per load (ack NUM_COLS+2 cycles after), or zeroes the frame on clear.
// Each mem_ready=0 cycle during a write stretches the operation by one cycle; addresses hold until accepted.
module vga_row_writer_fsm #(
  parameter int NUM_COLS  = 32,
  parameter int NUM_ROWS  = 256,
  parameter int COL_W     = $clog2(NUM_COLS),
  parameter int ROW_W     = $clog2(NUM_ROWS),
  parameter bit AUTO_WRAP = 1'b0
) (
  input logic                 clk_i,
  input logic                 reset_i,
  vga_row_writer_fsm_if.slave bus_if
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COPY,
    S_CLEAR,
    S_INCR,
    S_WAIT,
    S_ACK
  } state_e;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

  state_e           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    unique case (state_q)
      S_IDLE: begin
        // clear outranks load; a pending load is picked up again after the clear's ack
        if (bus_if.clear) begin
          state_d = S_CLEAR;
          col_d   = '0;
          row_d   = '0;
        end else if (bus_if.load) begin
          state_d = S_COPY;
        end
      end
      S_COPY: begin
        if (bus_if.mem_ready) begin
          if (col_q == LAST_COL) begin
            col_d   = '0;
            state_d = S_INCR;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      S_INCR: begin
        if (row_q == LAST_ROW) begin
          row_d   = '0;
          state_d = AUTO_WRAP ? S_ACK : S_WAIT;
        end else begin
          row_d   = row_q + ROW_W'(1);
          state_d = S_ACK;
        end
      end
      S_WAIT: begin
        if (!bus_if.key_n) begin
          state_d = S_ACK;
        end
      end
      S_CLEAR: begin
        if (bus_if.mem_ready) begin
          if (col_q == LAST_COL) begin
            col_d = '0;
            if (row_q == LAST_ROW) begin
              row_d   = '0;
              state_d = S_ACK;
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus_if.col        = col_q;
  assign bus_if.row        = row_q;
  assign bus_if.load_mem   = (state_q == S_COPY) || (state_q == S_CLEAR);
  assign bus_if.wr_clear   = (state_q == S_CLEAR);
  assign bus_if.ack        = (state_q == S_ACK);
  assign bus_if.frame_done = (state_q == S_INCR) && (row_q == LAST_ROW);
  assign bus_if.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_vga_row_writer_fsm.sv
// Directed bench: three row-writer instances (32x4 wait, 5x3 auto-wrap, 4x2 clear) driven in sequence.
module tb_vga_row_writer_fsm;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  vga_row_writer_fsm_if #(.COL_W(5), .ROW_W(2)) if_a ();
  vga_row_writer_fsm_if #(.COL_W(3), .ROW_W(2)) if_b ();
  vga_row_writer_fsm_if #(.COL_W(2), .ROW_W(1)) if_c ();

  vga_row_writer_fsm #(.NUM_COLS(32), .NUM_ROWS(4), .AUTO_WRAP(1'b0)) dut_a (
    .clk_i(clk), .reset_i(rst), .bus_if(if_a)
  );
  vga_row_writer_fsm #(.NUM_COLS(5), .NUM_ROWS(3), .AUTO_WRAP(1'b1)) dut_b (
    .clk_i(clk), .reset_i(rst), .bus_if(if_b)
  );
  vga_row_writer_fsm #(.NUM_COLS(4), .NUM_ROWS(2), .AUTO_WRAP(1'b0)) dut_c (
    .clk_i(clk), .reset_i(rst), .bus_if(if_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int ack_cyc, fd_cyc, exp_col, exp_row, n_ack, n_fd, max_col, max_row;

    rst = 1'b1;
    if_a.load = 1'b0; if_a.clear = 1'b0; if_a.key_n = 1'b1; if_a.mem_ready = 1'b1;
    if_b.load = 1'b0; if_b.clear = 1'b0; if_b.key_n = 1'b1; if_b.mem_ready = 1'b1;
    if_c.load = 1'b0; if_c.clear = 1'b0; if_c.key_n = 1'b1; if_c.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_col", if_a.col, 0);
    check("rst_row", if_a.row, 0);
    check("rst_load_mem", if_a.load_mem, 0);
    check("rst_wr_clear", if_a.wr_clear, 0);
    check("rst_ack", if_a.ack, 0);
    check("rst_frame_done", if_a.frame_done, 0);
    check("rst_busy_a", if_a.busy, 0);
    check("rst_busy_b", if_b.busy, 0);
    check("rst_busy_c", if_c.busy, 0);
    rst = 1'b0;

    // Row 0, mem_ready held high: ack lands on cycle 34
    @(negedge clk);
    if_a.load = 1'b1;
    ack_cyc = 0;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      if (c == 1) if_a.load = 1'b0;
      if (c <= 32) begin
        check("t1_load_mem", if_a.load_mem, 1);
        check("t1_col", if_a.col, c - 1);
      end
      if (c == 33) check("t1_incr_no_write", if_a.load_mem, 0);
      if (if_a.ack && ack_cyc == 0) ack_cyc = c;
    end
    check("t1_ack_cycle", ack_cyc, 34);
    check("t1_row_after", if_a.row, 1);
    check("t1_col_after", if_a.col, 0);

    // Row 1 with mem_ready stalling every other cycle: ack on cycle 66
    @(negedge clk);
    check("t2_idle", if_a.busy, 0);
    if_a.load = 1'b1;
    ack_cyc = 0;
    exp_col = 0;
    for (int c = 1; c <= 66; c++) begin
      @(negedge clk);
      if (c == 1) if_a.load = 1'b0;
      if_a.mem_ready = (c % 2 == 0);
      if (if_a.load_mem && if_a.mem_ready) begin
        check("t2_write_col", if_a.col, exp_col);
        exp_col++;
      end
      if (if_a.ack && ack_cyc == 0) ack_cyc = c;
    end
    if_a.mem_ready = 1'b1;
    check("t2_write_count", exp_col, 32);
    check("t2_ack_cycle", ack_cyc, 66);
    check("t2_row_after", if_a.row, 2);

    // Reset mid-row at col 10 abandons the row
    @(negedge clk);
    if_a.load = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 1) if_a.load = 1'b0;
    end
    check("t6_col_before", if_a.col, 10);
    check("t6_row_before", if_a.row, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_col", if_a.col, 0);
    check("t6_row", if_a.row, 0);
    check("t6_busy", if_a.busy, 0);
    check("t6_load_mem", if_a.load_mem, 0);
    check("t6_ack", if_a.ack, 0);
    n_ack = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_ack += int'(if_a.ack) + int'(if_a.busy);
    end
    check("t6_no_ack_after", n_ack, 0);

    // Four rows into a 4-row frame: frame_done on the 4th INCR, then WAIT for key
    for (int r = 0; r < 4; r++) begin
      if (r > 0) @(negedge clk);
      if_a.load = 1'b1;
      ack_cyc = 0;
      fd_cyc = 0;
      for (int c = 1; c <= 34; c++) begin
        @(negedge clk);
        if (c == 1) if_a.load = 1'b0;
        if (if_a.ack && ack_cyc == 0) ack_cyc = c;
        if (if_a.frame_done && fd_cyc == 0) fd_cyc = c;
      end
      if (r < 3) begin
        check("t3_ack_cycle", ack_cyc, 34);
        check("t3_no_frame_done", fd_cyc, 0);
        check("t3_row", if_a.row, r + 1);
      end else begin
        check("t3_frame_done_cycle", fd_cyc, 33);
        check("t3_no_ack_in_wait", ack_cyc, 0);
        check("t3_row_wrapped", if_a.row, 0);
        check("t3_busy_wait", if_a.busy, 1);
      end
    end
    n_ack = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_ack += int'(if_a.ack);
    end
    check("t3_hold_no_ack", n_ack, 0);
    check("t3_hold_busy", if_a.busy, 1);
    if_a.key_n = 1'b0;
    @(negedge clk);
    check("t3_key_ack", if_a.ack, 1);
    if_a.key_n = 1'b1;
    @(negedge clk);
    check("t3_idle_after_key", if_a.busy, 0);
    check("t3_row_after_key", if_a.row, 0);

    // 5x3 auto-wrap: load held until the third ack, addresses stay in range
    if_b.load = 1'b1;
    exp_col = 0; exp_row = 0; n_ack = 0; n_fd = 0; ack_cyc = 0; fd_cyc = 0;
    max_col = 0; max_row = 0;
    for (int c = 1; c <= 23; c++) begin
      @(negedge clk);
      if (int'(if_b.col) > max_col) max_col = int'(if_b.col);
      if (int'(if_b.row) > max_row) max_row = int'(if_b.row);
      if (if_b.load_mem) begin
        check("t4_col", if_b.col, exp_col);
        check("t4_row", if_b.row, exp_row);
        exp_col = (exp_col + 1) % 5;
        if (exp_col == 0) exp_row = (exp_row + 1) % 3;
      end
      if (if_b.frame_done) begin n_fd++; fd_cyc = c; end
      if (if_b.ack) begin
        n_ack++;
        ack_cyc = c;
        if (n_ack == 3) if_b.load = 1'b0;
      end
    end
    check("t4_ack_count", n_ack, 3);
    check("t4_third_ack_cycle", ack_cyc, 23);
    check("t4_frame_done_count", n_fd, 1);
    check("t4_frame_done_cycle", fd_cyc, 22);
    check("t4_row_after_wrap", if_b.row, 0);
    check("t4_max_col", max_col, 4);
    check("t4_max_row", max_row, 2);
    @(negedge clk);
    check("t4_idle", if_b.busy, 0);

    // clear and load together on 4x2: 8 zero writes, ack at 9, then COPY of row 0
    if_c.clear = 1'b1;
    if_c.load = 1'b1;
    n_fd = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1) if_c.clear = 1'b0;
      if (c <= 8) begin
        check("t5_wr_clear", if_c.wr_clear, 1);
        check("t5_load_mem", if_c.load_mem, 1);
        check("t5_col", if_c.col, (c - 1) % 4);
        check("t5_row", if_c.row, (c - 1) / 4);
      end
      if (c <= 10) n_fd += int'(if_c.frame_done);
      if (c == 9) check("t5_clear_ack", if_c.ack, 1);
      if (c == 11) begin
        check("t5_copy_load_mem", if_c.load_mem, 1);
        check("t5_copy_wr_clear", if_c.wr_clear, 0);
        check("t5_copy_row", if_c.row, 0);
        check("t5_copy_col", if_c.col, 0);
      end
      if (c == 16) begin
        check("t5_copy_ack", if_c.ack, 1);
        if_c.load = 1'b0;
      end
    end
    check("t5_no_frame_done", n_fd, 0);
    check("t5_row_after", if_c.row, 1);
    @(negedge clk);
    check("t5_idle", if_c.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
